raw_window_crop: RTL and testbench
==================================

// Module: raw_window_crop
// PURPOSE
// - Crops the RAW10 pixel stream (fv/lv/pd) from the byte-to-pixel converter to a window before
//   it reaches the Bayer demosaic stage, on the pixel clock.
// - Reports per-frame line count, a frame counter and short-line/short-frame error flags for the
//   SPI debug registers.
// PARAMETERS
// - X_OFFSET  default 0     first kept pixel in each line; must be even so Bayer phase is preserved
// - Y_OFFSET  default 0     first kept line in each frame; must be even
// - X_SIZE    default 1280  kept pixels per line; must be >= 2 and even
// - Y_SIZE    default 720   kept lines per frame; must be >= 2 and even
// - CNT_W     default 12    width of the x and y position counters
// PORTS
// - clk            in   1      pixel clock
// - reset_n        in   1      asynchronous, active-low reset
// - fv_i           in   1      frame valid from byte-to-pixel
// - lv_i           in   1      line valid from byte-to-pixel
// - pd_i           in   10     pixel data from byte-to-pixel
// - fv_o           out  1      frame valid to demosaic
// - lv_o           out  1      line valid to demosaic; only high for in-window pixels
// - pd_o           out  10     pixel data to demosaic
// - frame_count_o  out  8      completed frames, wraps at 255->0
// - lines_o        out  CNT_W  total input lines of the last completed frame
// - short_line_o   out  1      last frame had a line ending before X_OFFSET+X_SIZE pixels
// - short_frame_o  out  1      last frame ended before Y_OFFSET+Y_SIZE lines
// BEHAVIOUR
// - Reset: all outputs 0, both counters 0, FSM in IDLE.
// - Latency: exactly 1 clk, fv_i/lv_i/pd_i -> fv_o/lv_o/pd_o, for every sample.
// - pd_o is registered pd_i unconditionally; consumers qualify it with lv_o.
// - FSM IDLE: wait for fv_i to go 0->1 (rising edge detected on a registered copy of fv_i).
//   fv_i already high when reset releases is not a start; the FSM waits for the next rising edge.
// - On that rising edge: go to FRAME; clear x, y and the working error flags.
// - FRAME, position counting:
//   - x increments on each cycle with fv_i&lv_i; x clears when lv_i falls.
//   - y increments on each lv_i falling edge.
//   - x and y saturate at 2^CNT_W-1 and never wrap.
// - FRAME, window: lv_o = fv_i & lv_i & (x in [X_OFFSET, X_OFFSET+X_SIZE-1])
//   & (y in [Y_OFFSET, Y_OFFSET+Y_SIZE-1]), evaluated on the current x and y.
// - FRAME, short line: a falling edge of lv_i while y is in the window and
//   x < X_OFFSET+X_SIZE sets the working short_line flag.
// - FRAME, lv_i without fv_i: ignored; lv_o stays 0 and counters do not move.
// - fv_o = registered fv_i, held 0 while in IDLE.
// - fv_i falling edge in FRAME, frame end:
//   - lines_o <= y, plus 1 if lv_i falls in the same cycle.
//   - short_frame_o <= (final y < Y_OFFSET+Y_SIZE).
//   - short_line_o <= working short_line flag.
//   - frame_count_o increments by 1.
//   - FSM returns to IDLE.
// - fv_i falling during an active line: lv_o is 0 from the next cycle, and that line counts as
//   ended for both y and the short_line check.
// - Result outputs change only at frame end; they are stable for the whole following frame.
// - lv_i rising and falling in consecutive cycles (1-pixel line) is legal and counted normally.
// CONFIGURATION
// - CROP_STATS_EN defined:
//   - extra ports sum_o out 32 and sum_valid_o out 1.
//   - sum_o is the sum of pd_i over every in-window pixel of the frame; 32-bit, wraps modulo 2^32.
//   - sum_o is latched at frame end; sum_valid_o pulses high for 1 clk in the same cycle;
//     both are 0 at reset.
// - CROP_STATS_EN undefined: no extra ports; no accumulator logic is built.
// TESTING
// - Frame 8 lines x 16 px, X_OFFSET=2, X_SIZE=4, Y_OFFSET=2, Y_SIZE=4, pd=x+16*y
//   -> lv_o high for 4 px on lines 2..5; pd_o = 34..37 on first kept line; lines_o=8;
//   frame_count_o=1; both error flags 0.
// - Same window, line 3 only 5 px long -> short_line_o=1 after frame end;
//   next clean frame -> short_line_o=0.
// - Same window, fv_i falls after 4 lines -> short_frame_o=1, lines_o=4, lv_o never high on line 4+.
// - Reset_n asserted mid-line of line 3 -> all outputs 0 immediately; no output until the next
//   fv_i rising edge; fv_i held high through reset release yields no frame.
// - 256 back-to-back frames -> frame_count_o wraps 255->0;
//   lv_i pulses with fv_i=0 between frames -> lv_o stays 0.
// - CROP_STATS_EN with the first scenario -> sum_o = sum of 34..37, 50..53, 66..69, 82..85 = 952;
//   sum_valid_o is a single-cycle pulse.

Source files
------------

// File: rtl/raw_window_crop.sv
// Crops a RAW10 fv/lv/pd stream to a fixed Bayer-aligned window with 1-clk latency and reports
// per-frame line count, frame counter and short-line/short-frame flags; CROP_STATS_EN adds a pixel sum.
module raw_window_crop #(
   parameter int X_OFFSET = 0,
   parameter int Y_OFFSET = 0,
   parameter int X_SIZE   = 1280,
   parameter int Y_SIZE   = 720,
   parameter int CNT_W    = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fv_i,
   input  logic             lv_i,
   input  logic [9:0]       pd_i,
   output logic             fv_o,
   output logic             lv_o,
   output logic [9:0]       pd_o,
   output logic [7:0]       frame_count_o,
   output logic [CNT_W-1:0] lines_o,
   output logic             short_line_o,
   output logic             short_frame_o
`ifdef CROP_STATS_EN
   ,
   output logic [31:0]      sum_o,
   output logic             sum_valid_o
`endif
);

   localparam logic [31:0]      X_LO    = 32'(X_OFFSET);
   localparam logic [31:0]      Y_LO    = 32'(Y_OFFSET);
   localparam logic [31:0]      X_SZ    = 32'(X_SIZE);
   localparam logic [31:0]      Y_SZ    = 32'(Y_SIZE);
   localparam logic [31:0]      X_END   = 32'(X_OFFSET + X_SIZE);
   localparam logic [31:0]      Y_END   = 32'(Y_OFFSET + Y_SIZE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE, S_FRAME} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_fv_d;
   logic             r_act_d;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_short_line;

   logic             w_start;
   logic             w_end;
   logic             w_act;
   logic             w_pix;
   logic             w_lend;
   logic             w_y_in;
   logic             w_in_win;
   logic             w_short_hit;
   logic             w_sl_nxt;
   logic [CNT_W-1:0] w_x;
   logic [CNT_W-1:0] w_y;
   logic [CNT_W-1:0] w_x_nxt;
   logic [CNT_W-1:0] w_y_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (fv_i && !r_fv_d) w_state_nxt = S_FRAME;
         S_FRAME: if (!fv_i)           w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_start = 1'b0;
      w_end   = 1'b0;
      w_act   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start = fv_i & ~r_fv_d;
            w_act   = fv_i & ~r_fv_d;
         end
         S_FRAME: begin
            w_act = 1'b1;
            w_end = ~fv_i;
         end
      endcase
   end

   // The rising-edge cycle already belongs to the frame, seen with freshly cleared counters.
   assign w_x    = w_start ? '0 : r_x;
   assign w_y    = w_start ? '0 : r_y;
   assign w_pix  = w_act & fv_i & lv_i;
   // A line ends when the previous cycle carried a pixel and this one does not (lv or fv fell).
   assign w_lend = w_act & r_act_d & ~(fv_i & lv_i);

   // Unsigned wrap makes (pos - lo) < size a single-sided range test.
   assign w_y_in      = (32'(w_y) - Y_LO) < Y_SZ;
   assign w_in_win    = w_pix && ((32'(w_x) - X_LO) < X_SZ) && w_y_in;
   assign w_short_hit = w_lend && w_y_in && (32'(w_x) < X_END);

   assign w_x_nxt  = w_lend ? '0 :
                     (w_pix && (w_x != CNT_MAX)) ? w_x + 1'b1 : w_x;
   assign w_y_nxt  = (w_lend && (w_y != CNT_MAX)) ? w_y + 1'b1 : w_y;
   assign w_sl_nxt = (w_start ? 1'b0 : r_short_line) | w_short_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // Held high in reset so fv_i already high at release is not taken as a frame start.
         r_fv_d        <= 1'b1;
         r_act_d       <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_short_line  <= 1'b0;
         fv_o          <= 1'b0;
         lv_o          <= 1'b0;
         pd_o          <= '0;
         frame_count_o <= '0;
         lines_o       <= '0;
         short_line_o  <= 1'b0;
         short_frame_o <= 1'b0;
      end else begin
         r_fv_d  <= fv_i;
         r_act_d <= fv_i & lv_i;
         pd_o    <= pd_i;
         fv_o    <= fv_i & w_act;
         lv_o    <= w_in_win;
         if (w_act) begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_short_line <= w_sl_nxt;
         end
         if (w_end) begin
            lines_o       <= w_y_nxt;
            short_frame_o <= 32'(w_y_nxt) < Y_END;
            short_line_o  <= w_sl_nxt;
            frame_count_o <= frame_count_o + 8'd1;
         end
      end
   end

`ifdef CROP_STATS_EN
   logic [31:0] r_acc;
   logic [31:0] w_acc_nxt;

   assign w_acc_nxt = (w_start ? 32'd0 : r_acc) + (w_in_win ? 32'(pd_i) : 32'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc       <= '0;
         sum_o       <= '0;
         sum_valid_o <= 1'b0;
      end else begin
         sum_valid_o <= w_end;
         if (w_act) r_acc <= w_acc_nxt;
         if (w_end) sum_o <= w_acc_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_raw_window_crop.sv
// Randomised frame-level bench for raw_window_crop; expected outputs come from the frame generator's
// own line/pixel indices and per-frame line lengths.
module tb_raw_window_crop;

   localparam int XO = 2;
   localparam int XS = 4;
   localparam int YO = 2;
   localparam int YS = 4;
   localparam int CW = 12;
   localparam int XE = XO + XS;
   localparam int YE = YO + YS;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fv_i = 1'b0;
   logic          lv_i = 1'b0;
   logic [9:0]    pd_i = '0;
   logic          fv_o;
   logic          lv_o;
   logic [9:0]    pd_o;
   logic [7:0]    frame_count_o;
   logic [CW-1:0] lines_o;
   logic          short_line_o;
   logic          short_frame_o;
`ifdef CROP_STATS_EN
   logic [31:0]   sum_o;
   logic          sum_valid_o;
`endif

   raw_window_crop #(
      .X_OFFSET(XO), .Y_OFFSET(YO), .X_SIZE(XS), .Y_SIZE(YS), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .fv_i(fv_i), .lv_i(lv_i), .pd_i(pd_i),
      .fv_o(fv_o), .lv_o(lv_o), .pd_o(pd_o), .frame_count_o(frame_count_o),
      .lines_o(lines_o), .short_line_o(short_line_o), .short_frame_o(short_frame_o)
`ifdef CROP_STATS_EN
      , .sum_o(sum_o), .sum_valid_o(sum_valid_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        fv;
      logic        lv;
      logic [9:0]  pd;
      logic [7:0]  fc;
      logic [11:0] lines;
      logic        sl;
      logic        sf;
      logic [31:0] sum;
      logic        sv;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 0;
   exp_t        exp_cur = '0;
   exp_t        exp_nxt = '0;

   // model: frame-level state and the results of the frame being generated
   bit          m_on = 0;
   bit          m_prev_fv = 1;
   int          m_fc = 0;
   int          m_lines = 0;
   bit          m_sl = 0;
   bit          m_sf = 0;
   bit          m_sv = 0;
   logic [31:0] m_sum = '0;
   int          p_lines = 0;
   bit          p_sl = 0;
   logic [31:0] p_sum = '0;
   int          len [16];
   logic [9:0]  cap [$];
   int          n_sv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("fv_o", 32'(fv_o), 32'(exp_cur.fv));
         chk("lv_o", 32'(lv_o), 32'(exp_cur.lv));
         chk("pd_o", 32'(pd_o), 32'(exp_cur.pd));
         chk("frame_count_o", 32'(frame_count_o), 32'(exp_cur.fc));
         chk("lines_o", 32'(lines_o), 32'(exp_cur.lines));
         chk("short_line_o", 32'(short_line_o), 32'(exp_cur.sl));
         chk("short_frame_o", 32'(short_frame_o), 32'(exp_cur.sf));
`ifdef CROP_STATS_EN
         chk("sum_o", sum_o, exp_cur.sum);
         chk("sum_valid_o", 32'(sum_valid_o), 32'(exp_cur.sv));
         if (sum_valid_o) n_sv++;
`endif
         if (lv_o) cap.push_back(pd_o);
      end
   end

   // One input sample: a frame starts on a 0->1 of fv seen after reset, ends when fv drops.
   task automatic drive(input bit fv, input bit lv, input logic [9:0] pd, input bit win);
      @(posedge clk);
      #1;
      exp_cur = exp_nxt;
      fv_i = fv;
      lv_i = lv;
      pd_i = pd;
      if (!m_on && fv && !m_prev_fv) m_on = 1;
      exp_nxt.fv = fv & m_on;
      exp_nxt.lv = fv & lv & m_on & win;
      exp_nxt.pd = pd;
      m_sv = 0;
      if (m_on && !fv) begin
         m_fc    = (m_fc + 1) % 256;
         m_lines = p_lines;
         m_sl    = p_sl;
         m_sf    = (p_lines < YE);
         m_sum   = p_sum;
         m_sv    = 1;
         m_on    = 0;
      end
      exp_nxt.fc    = 8'(m_fc);
      exp_nxt.lines = 12'(m_lines);
      exp_nxt.sl    = m_sl;
      exp_nxt.sf    = m_sf;
      exp_nxt.sum   = m_sum;
      exp_nxt.sv    = m_sv;
      m_prev_fv = fv;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_fv_o"}, 32'(fv_o), 0);
      chk({tag, "_lv_o"}, 32'(lv_o), 0);
      chk({tag, "_pd_o"}, 32'(pd_o), 0);
      chk({tag, "_frame_count_o"}, 32'(frame_count_o), 0);
      chk({tag, "_lines_o"}, 32'(lines_o), 0);
      chk({tag, "_short_line_o"}, 32'(short_line_o), 0);
      chk({tag, "_short_frame_o"}, 32'(short_frame_o), 0);
   endtask

   task automatic release_reset();
      m_on = 0; m_fc = 0; m_lines = 0; m_sl = 0; m_sf = 0; m_sum = '0; m_sv = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_cur = '0;
      exp_nxt = '0;
      exp_nxt.pd = pd_i;
      m_prev_fv = fv_i;
      chk_en = 1;
   endtask

   // Called right after a drive(); asserts reset between clock edges.
   task automatic do_reset();
      chk_en = 0;
      #2 reset_n = 1'b0;
      #1;
      check_zero("reset");
      release_reset();
   endtask

   task automatic send_frame(input int nl, input bit trunc, input bit stray, input bit rnd_pd,
                             input int rst_line);
      int         ng;
      logic [9:0] pdv;
      bit         win;
      p_lines = 0;
      p_sl    = 0;
      p_sum   = '0;
      ng = $urandom_range(2, 4);
      for (int g = 0; g < ng; g++) drive(1'b0, stray ? 1'($urandom_range(0, 1)) : 1'b0, 10'($urandom), 1'b1);
      ng = $urandom_range(1, 3);
      for (int g = 0; g < ng; g++) drive(1'b1, 1'b0, 10'($urandom), 1'b0);
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < len[l]; p++) begin
            pdv = rnd_pd ? 10'($urandom) : 10'(p + 16 * l);
            win = (l >= YO) && (l < YE) && (p >= XO) && (p < XE);
            drive(1'b1, 1'b1, pdv, win);
            if (win) p_sum += 32'(pdv);
            if (l == rst_line && p == 1) begin
               do_reset();
               return;
            end
         end
         p_lines++;
         if (l >= YO && l < YE && len[l] < XE) p_sl = 1;
         if (!(trunc && l == nl - 1)) begin
            ng = $urandom_range(1, 2);
            for (int g = 0; g < ng; g++) drive(1'b1, 1'b0, 10'($urandom), 1'b0);
         end
      end
      drive(1'b0, trunc, 10'($urandom), 1'b1);
      drive(1'b0, 1'b0, 10'($urandom), 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_zero("por");
      release_reset();

      // Basic window: 8 lines of 16 px, pd = x + 16*y
      for (int l = 0; l < 16; l++) len[l] = 16;
      cap.delete();
      n_sv = 0;
      send_frame(8, 0, 0, 0, -1);
      chk("s1_lines", 32'(lines_o), 8);
      chk("s1_frame_count", 32'(frame_count_o), 1);
      chk("s1_short_line", 32'(short_line_o), 0);
      chk("s1_short_frame", 32'(short_frame_o), 0);
      chk("s1_kept_px", cap.size(), 16);
      for (int i = 0; i < 4; i++)
         chk("s1_first_pd", (cap.size() > i) ? 32'(cap[i]) : 32'hFFFF, 32'(34 + i));
`ifdef CROP_STATS_EN
      chk("s1_sum", sum_o, 952);
      chk("s1_sum_pulses", n_sv, 1);
`endif

      // Short line 3, then a clean frame clears the flag
      len[3] = 5;
      send_frame(8, 0, 1, 0, -1);
      chk("s2_short_line", 32'(short_line_o), 1);
      chk("s2_lines", 32'(lines_o), 8);
      len[3] = 16;
      send_frame(8, 0, 1, 0, -1);
      chk("s2_clean_short_line", 32'(short_line_o), 0);
      chk("s2_frame_count", 32'(frame_count_o), 3);

      // Short frame: fv drops after 4 lines
      cap.delete();
      send_frame(4, 0, 0, 0, -1);
      chk("s3_lines", 32'(lines_o), 4);
      chk("s3_short_frame", 32'(short_frame_o), 1);
      chk("s3_kept_px", cap.size(), 8);

      // fv drops while line 4 is still active: that line still counts
      send_frame(5, 1, 0, 0, -1);
      chk("s3b_lines", 32'(lines_o), 5);

      // Reset mid-line of line 3, fv held high through release
      send_frame(8, 0, 0, 0, 3);
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < 8; p++) drive(1'b1, 1'b1, 10'($urandom), 1'b1);
         drive(1'b1, 1'b0, 10'($urandom), 1'b0);
      end
      drive(1'b0, 1'b0, 10'($urandom), 1'b0);
      drive(1'b0, 1'b0, 10'($urandom), 1'b0);
      chk("s4_no_frame_count", 32'(frame_count_o), 0);
      chk("s4_no_frame_lines", 32'(lines_o), 0);
      send_frame(8, 0, 0, 0, -1);
      chk("s4_after_frame_count", 32'(frame_count_o), 1);
      chk("s4_after_lines", 32'(lines_o), 8);

      // Randomised frames: line lengths, line count, gaps, truncation, stray lv
      for (int f = 0; f < 30; f++) begin
         int nl;
         bit tr;
         nl = $urandom_range(0, 9);
         for (int l = 0; l < 16; l++) len[l] = $urandom_range(1, 10);
         tr = (nl > 0) && ($urandom_range(0, 3) == 0);
         send_frame(nl, tr, 1, 1, -1);
      end

      // Frame counter wrap
      do_reset();
      for (int l = 0; l < 16; l++) len[l] = 2;
      for (int f = 0; f < 255; f++) send_frame(2, 0, 1, 1, -1);
      chk("wrap_255", 32'(frame_count_o), 255);
      send_frame(2, 0, 1, 1, -1);
      chk("wrap_0", 32'(frame_count_o), 0);
      chk("wrap_lines", 32'(lines_o), 2);
      chk("wrap_short_frame", 32'(short_frame_o), 1);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
